data_mem_lsu: RTL and testbench

Parametrised successor to the single-cycle data memory stage. It is a load/store unit with internal word-organised data RAM, and it supports all RV32 load and store widths: LB, LH, LW, LBU, LHU, SB, SH, SW. It adds three things the single-cycle stage lacks: a valid/ready request handshake, a registered response, and optional splitting of misaligned accesses into two RAM beats. It sits in the MEM stage; the pipeline stalls on busy.

---
 rtl/data_mem_lsu_pkg.sv | 52 +++++
 rtl/data_mem_lsu_if.sv | 40 ++++
 rtl/data_mem_lsu_byte_ram.sv | 30 +++
 rtl/data_mem_lsu.sv | 155 +++++++++++++++
 tb/tb_data_mem_lsu.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_lsu_pkg.sv
// data_mem_lsu_pkg
// Shared definitions for the data-memory load/store unit.
//   F3_*         : RV32 load/store funct3 encodings
//   state_t      : controller states (IDLE, BEAT2, RESP)
//   lane_t       : byte enables and lane-rotated store data spanning two words
//   size_bytes() : access size in bytes from funct3 (0 marks an illegal size code)
//   lane_rotate(): byte enables and store data rotated into position by the byte offset
package data_mem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT2 = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Bits [3:0]/[31:0] belong to the first word, [7:4]/[63:32] to the next one.
  typedef struct packed {
    logic [7:0]  be;
    logic [63:0] data;
  } lane_t;

  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic lane_t lane_rotate(input logic [2:0] size, input logic [1:0] off,
                                        input logic [31:0] wdata);
    lane_t      l;
    logic [7:0] mask;
    case (size)
      3'd1:    mask = 8'h01;
      3'd2:    mask = 8'h03;
      3'd4:    mask = 8'h0F;
      default: mask = 8'h00;
    endcase
    l.be   = mask << off;
    l.data = {32'b0, wdata} << {off, 3'b000};
    return l;
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu_if
// Request/response bundle between the MEM stage and the load/store unit.
//   req_valid/req_ready : request handshake; req_we, req_funct3, req_addr, req_wdata
//   resp_valid          : one-cycle response pulse with resp_rdata and resp_err
//   busy                : unit occupied (pipeline stall)
//   fsm_state           : controller state, for observation only
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; every req_* field is captured at that edge. The unit
// drives req_ready only while it is idle and never queues: a request that sees
// req_ready low is simply not taken and must be held by the requester. Each
// accepted request yields exactly one resp_valid pulse, unless reset intervenes.
interface data_mem_lsu_if #(
  parameter int ADDR_W = 32
);
  import data_mem_lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              busy;
  state_t            fsm_state;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy, fsm_state
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy, fsm_state
  );

endinterface

// File: rtl/data_mem_lsu_byte_ram.sv
// lsu_byte_ram
// DEPTH_WORDS x 32 single-port RAM with per-byte write enables and a registered
// read port. Kept as its own module so it can be replaced by a technology macro.
//   clk   : rising-edge clock
//   en    : read enable; rdata updates only when set
//   be    : byte write enables, bit i writes wdata[8i+7:8i]
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (old contents on a same-cycle write)
module lsu_byte_ram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu
// MEM-stage load/store unit with internal word-organised RAM. Handles RV32
// LB/LH/LW/LBU/LHU/SB/SH/SW, returns a registered response one cycle after
// accept, and (with MISALIGN_SPLIT=1) splits word-crossing accesses into two
// RAM beats, answering one cycle later.
//   clk, rst : clock, synchronous active-high reset
//   bus      : data_mem_lsu_if slave (request, response, busy, fsm_state)
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input logic           clk,
  input logic           rst,
  data_mem_lsu_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W+1)'(DEPTH_WORDS) << 2;

  state_t state;

  // Request fields held for the remainder of the transaction
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [AW-1:0] word_q;
  logic          err_q;
  logic          split_q;
  logic [3:0]    be_hi_q;
  logic [31:0]   wdata_hi_q;
  logic [31:0]   beat1_q;

  logic          accept;
  logic [2:0]    size;
  logic          illegal_f3;
  logic          out_of_range;
  logic          misaligned;
  logic          crosses;
  logic          req_err;
  logic [ADDR_W:0] last_addr;
  lane_t         lane_in;

  logic          ram_en;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic [63:0]   joined;
  logic [31:0]   shifted;

  assign accept     = bus.req_valid && (state == IDLE);
  assign size       = size_bytes(bus.req_funct3);
  assign illegal_f3 = (bus.req_funct3[1:0] == 2'b11) ||
                      (bus.req_funct3[2] && (bus.req_funct3[1] || bus.req_we));
  // One extra bit so an access at the top of the address space cannot wrap.
  assign last_addr    = {1'b0, bus.req_addr} + (ADDR_W+1)'(size) - (ADDR_W+1)'(1);
  assign out_of_range = last_addr >= BYTE_LIMIT;
  assign misaligned   = (bus.req_addr[0] && size >= 3'd2) ||
                        ((bus.req_addr[1:0] != 2'b00) && size == 3'd4);
  // Crossing a word boundary implies misaligned, so in reject mode it is an error.
  assign crosses      = ({1'b0, bus.req_addr[1:0]} + size) > 3'd4;
  assign req_err      = illegal_f3 || out_of_range || (misaligned && !MISALIGN_SPLIT);
  assign lane_in      = lane_rotate(size, bus.req_addr[1:0], bus.req_wdata);

  // RAM port: beat 1 is driven straight from the request so the read/write
  // happens on the accept edge; beat 2 uses the captured fields. Writes are
  // suppressed under reset so an interrupted split keeps only its first beat.
  always_comb begin
    ram_en    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = bus.req_addr[AW+1:2];
    ram_wdata = lane_in.data[31:0];
    case (state)
      IDLE: begin
        ram_en = accept;
        if (accept && bus.req_we && !req_err && !rst) ram_be = lane_in.be[3:0];
      end
      BEAT2: begin
        ram_en    = 1'b1;
        ram_addr  = word_q + AW'(1);
        ram_wdata = wdata_hi_q;
        if (!rst) ram_be = be_hi_q;
      end
      default: ;
    endcase
  end

  lsu_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q       <= bus.req_we;
            f3_q       <= bus.req_funct3;
            off_q      <= bus.req_addr[1:0];
            word_q     <= bus.req_addr[AW+1:2];
            err_q      <= req_err;
            split_q    <= !req_err && crosses;
            be_hi_q    <= bus.req_we ? lane_in.be[7:4] : 4'b0000;
            wdata_hi_q <= lane_in.data[63:32];
            state      <= (!req_err && crosses) ? BEAT2 : RESP;
          end
        end
        BEAT2: begin
          beat1_q <= ram_rdata;
          state   <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Little-endian join of the two beats, then shift the addressed byte to bit 0.
  assign joined  = split_q ? {ram_rdata, beat1_q} : {32'b0, ram_rdata};
  assign shifted = 32'(joined >> {off_q, 3'b000});

  always_comb begin
    bus.resp_rdata = '0;
    if (state == RESP && !err_q && !we_q) begin
      case (f3_q[1:0])
        2'b00:   bus.resp_rdata = f3_q[2] ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
        2'b01:   bus.resp_rdata = f3_q[2] ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
        default: bus.resp_rdata = shifted;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = (state == RESP) && err_q;
  // Busy covers the accept cycle itself (request present while idle) through the response.
  assign bus.busy       = (state != IDLE) || bus.req_valid;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu
// Drives a split-mode and a reject-mode data_mem_lsu from one request driver
// and checks both against a byte-array model of the memory and the access rules.
module tb_data_mem_lsu;
  import data_mem_lsu_pkg::*;

  localparam int DEPTH  = 64;
  localparam int NBYTES = DEPTH * 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- request signals and DUTs ----------------
  logic        sel = 1'b0;  // 0: split instance, 1: reject instance
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;

  data_mem_lsu_if #(.ADDR_W(32)) if_s ();
  data_mem_lsu_if #(.ADDR_W(32)) if_n ();

  assign if_s.req_valid  = req_valid && !sel;
  assign if_s.req_we     = req_we;
  assign if_s.req_funct3 = req_funct3;
  assign if_s.req_addr   = req_addr;
  assign if_s.req_wdata  = req_wdata;
  assign if_n.req_valid  = req_valid && sel;
  assign if_n.req_we     = req_we;
  assign if_n.req_funct3 = req_funct3;
  assign if_n.req_addr   = req_addr;
  assign if_n.req_wdata  = req_wdata;

  data_mem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) dut_s (
    .clk (clk), .rst (rst), .bus (if_s)
  );
  data_mem_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) dut_n (
    .clk (clk), .rst (rst), .bus (if_n)
  );

  logic        d_ready, d_valid, d_err, d_busy;
  logic [31:0] d_rdata;
  assign d_ready = sel ? if_n.req_ready  : if_s.req_ready;
  assign d_valid = sel ? if_n.resp_valid : if_s.resp_valid;
  assign d_err   = sel ? if_n.resp_err   : if_s.resp_err;
  assign d_busy  = sel ? if_n.busy       : if_s.busy;
  assign d_rdata = sel ? if_n.resp_rdata : if_s.resp_rdata;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem_m [2][NBYTES];
  int          exp_cyc_q[$];
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          fl_start = 1;
  int          fl_end = 0;
  bit          chk_en = 1'b0;
  logic [2:0]  legal_f3 [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d, sel %0d)", name, act, exp, cyc, sel);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Byte-addressed memory per instance; abort keeps only the bytes of the first word.
  task automatic model_req(input int idx, input logic we, input logic [2:0] f3, input int addr,
                           input logic [31:0] wd, input bit abort,
                           output logic [31:0] rd, output logic err, output int lat);
    int          sz;
    bit          illegal, mis, crossing;
    logic [31:0] v;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : (f3[1:0] == 2'b10) ? 4 : 0;
    illegal  = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) ||
               (we && (f3 == F3_BU || f3 == F3_HU));
    mis      = (sz > 1) && ((addr % sz) != 0);
    crossing = ((addr % 4) + sz) > 4;
    err      = illegal || (addr + sz - 1 >= NBYTES) || (mis && idx == 1);
    lat      = (!err && crossing) ? 2 : 1;
    rd       = 32'b0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < sz; i++) begin
          if (!abort || ((addr % 4) + i) < 4) mem_m[idx][addr + i] = wd[8*i +: 8];
        end
      end else begin
        v = 32'b0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mem_m[idx][addr + i];
        case (sz)
          1:       rd = f3[2] ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
          2:       rd = f3[2] ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
          default: rd = v;
        endcase
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the accept edge with
  // req_valid still high so back-to-back requests keep it asserted.
  task automatic do_req(input logic we, input logic [2:0] f3, input int addr,
                        input logic [31:0] wd, input bit abort,
                        output logic [31:0] m_rd, output logic m_err,
                        output int m_lat, output int acc);
    int n;
    n = 0;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    while (!d_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    m_rd = 32'b0; m_err = 1'b0; m_lat = 0; acc = -1;
    if (!d_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", d_ready, n);
      req_valid = 1'b0;
      return;
    end
    acc = cyc;
    model_req(int'(sel), we, f3, addr, wd, abort, m_rd, m_err, m_lat);
    if (!abort) begin
      exp_cyc_q.push_back(cyc + m_lat);
      exp_q.push_back(m_rd);
      exp_err_q.push_back(m_err);
    end
    fl_start = cyc + 1;
    fl_end   = abort ? cyc + 1 : cyc + m_lat;
    @(posedge clk); #1;
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input int addr, input logic [31:0] wd);
    logic [31:0] rd;
    logic        e;
    int          lat, acc;
    do_req(we, f3, addr, wd, 1'b0, rd, e, lat, acc);
  endtask

  task automatic req_lit(input string name, input logic we, input logic [2:0] f3, input int addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          lat, acc;
    do_req(we, f3, addr, wd, 1'b0, rd, e, lat, acc);
    check({name, "_rdata"}, rd, exp_rd);
    check({name, "_err"}, 32'(e), 32'(exp_err));
  endtask

  task automatic drain();
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic random_ops(input int n);
    logic [2:0] f3;
    for (int k = 0; k < n; k++) begin
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      req(1'($urandom_range(0, 1)), f3, $urandom_range(0, NBYTES + 3), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    logic exp_v;
    logic exp_rdy;
    if (chk_en) begin
      exp_v   = (exp_cyc_q.size() != 0) && (exp_cyc_q[0] == cyc);
      exp_rdy = !(cyc >= fl_start && cyc <= fl_end);
      check("req_ready", 32'(d_ready), 32'(exp_rdy));
      check("busy", 32'(d_busy), 32'(req_valid || !exp_rdy));
      check("resp_valid", 32'(d_valid), 32'(exp_v));
      if (exp_v) begin
        if (d_valid) begin
          check("resp_rdata", d_rdata, exp_q[0]);
          check("resp_err", 32'(d_err), 32'(exp_err_q[0]));
        end
        void'(exp_cyc_q.pop_front());
        void'(exp_q.pop_front());
        void'(exp_err_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat, acc, prev_acc;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_s", 32'(if_s.req_ready), 32'd1);
    check("rst_valid_s", 32'(if_s.resp_valid), 32'd0);
    check("rst_rdata_s", if_s.resp_rdata, 32'd0);
    check("rst_err_s", 32'(if_s.resp_err), 32'd0);
    check("rst_busy_s", 32'(if_s.busy), 32'd0);
    check("rst_ready_n", 32'(if_n.req_ready), 32'd1);
    check("rst_busy_n", 32'(if_n.busy), 32'd0);
    @(posedge clk); #1;
    chk_en = 1'b1;

    // ---- split instance ----
    sel = 1'b0;
    for (int w = 0; w < DEPTH; w++) req(1'b1, F3_W, w * 4, $urandom);
    req_lit("sw0", 1'b1, F3_W, 0, 32'hDDCCBBAA, 32'h0, 1'b0);
    req_lit("lw0", 1'b0, F3_W, 0, 32'h0, 32'hDDCCBBAA, 1'b0);
    req_lit("sb1", 1'b1, F3_B, 1, 32'h000000EE, 32'h0, 1'b0);
    req_lit("lw0b", 1'b0, F3_W, 0, 32'h0, 32'hDDCCEEAA, 1'b0);
    req_lit("lb1", 1'b0, F3_B, 1, 32'h0, 32'hFFFFFFEE, 1'b0);
    req_lit("lbu1", 1'b0, F3_BU, 1, 32'h0, 32'h000000EE, 1'b0);
    req_lit("lh2", 1'b0, F3_H, 2, 32'h0, 32'hFFFFDDCC, 1'b0);
    req_lit("sw4", 1'b1, F3_W, 4, 32'h44332211, 32'h0, 1'b0);
    do_req(1'b0, F3_W, 3, 32'h0, 1'b0, rd, e, lat, acc);
    check("lw3_rdata", rd, 32'h332211DD);
    check("lw3_latency", 32'(lat), 32'd2);
    req_lit("sw2", 1'b1, F3_W, 2, 32'h88776655, 32'h0, 1'b0);
    req_lit("lw0c", 1'b0, F3_W, 0, 32'h0, 32'h6655EEAA, 1'b0);
    req_lit("lw4", 1'b0, F3_W, 4, 32'h0, 32'h44338877, 1'b0);
    req_lit("sw_range", 1'b1, F3_W, NBYTES - 2, 32'h12345678, 32'h0, 1'b1);
    req(1'b0, F3_W, NBYTES - 4, 32'h0);
    req_lit("f3_011", 1'b0, 3'b011, 0, 32'h0, 32'h0, 1'b1);
    req_lit("lbu_we", 1'b1, F3_BU, 0, 32'h0, 32'h0, 1'b1);
    drain();

    // req_valid held high: one acceptance every 2 cycles
    prev_acc = -1;
    for (int k = 0; k < 6; k++) begin
      do_req(1'b0, F3_W, 8 * k, 32'h0, 1'b0, rd, e, lat, acc);
      if (k > 0) check("stream_spacing", 32'(acc - prev_acc), 32'd2);
      prev_acc = acc;
    end
    drain();

    // reset while the second beat of a split store is pending
    do_req(1'b1, F3_W, 2, 32'h0D0C0B0A, 1'b1, rd, e, lat, acc);
    rst = 1'b1;
    req_valid = 1'b0;
    fl_end = cyc;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(d_ready), 32'd1);
    check("midrst_valid", 32'(d_valid), 32'd0);
    check("midrst_rdata", d_rdata, 32'd0);
    check("midrst_err", 32'(d_err), 32'd0);
    check("midrst_busy", 32'(d_busy), 32'd0);
    @(posedge clk); #1;
    req_lit("midrst_w0", 1'b0, F3_W, 0, 32'h0, 32'h0B0AEEAA, 1'b0);
    req_lit("midrst_w1", 1'b0, F3_W, 4, 32'h0, 32'h44338877, 1'b0);
    drain();
    random_ops(200);
    drain();

    // ---- reject instance ----
    sel = 1'b1;
    for (int w = 0; w < DEPTH; w++) req(1'b1, F3_W, w * 4, $urandom);
    req_lit("n_sw0", 1'b1, F3_W, 0, 32'h12345678, 32'h0, 1'b0);
    req_lit("n_lh1", 1'b0, F3_H, 1, 32'h0, 32'h0, 1'b1);
    req_lit("n_lw0", 1'b0, F3_W, 0, 32'h0, 32'h12345678, 1'b0);
    req_lit("n_sw2", 1'b1, F3_W, 2, 32'hCAFEF00D, 32'h0, 1'b1);
    req_lit("n_lw0b", 1'b0, F3_W, 0, 32'h0, 32'h12345678, 1'b0);
    req_lit("n_lb3", 1'b0, F3_B, 3, 32'h0, 32'h00000012, 1'b0);
    random_ops(150);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
